// File: rtl/sat_add_arbiter.sv
// One N-bit signed saturating adder shared round-robin by NREQ requesters.
// Result registered with 1-cycle latency; a stalled output register blocks every requester.
module sat_add_arbiter #(
  parameter int N    = 25,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_sat,
  output logic [CNTW-1:0]   sat_cnt,
  input  logic              sat_clr,
  output logic              busy
);

  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAX = {1'b1, {(N-2){1'b0}}, 1'b1};

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_sat_q, res_sat_d;
  logic [CNTW-1:0] sat_cnt_q, sat_cnt_d;

  logic           can_acc;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic           hs;
  logic [N-1:0]   a_sel, b_sel, raw_sum, sum_sat;
  logic           pos_ovf, neg_ovf;

  assign can_acc = !res_valid_q || res_ready;

  // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cidx;
    cand    = 0;
    cidx    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IDW'(cand);
      if (!gnt_vld && req_valid[cidx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cidx;
      end
    end
  end

  assign hs = gnt_vld && can_acc;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = hs && (gnt_idx == IDW'(i));
    end
  end

  assign a_sel   = req_a[gnt_idx*N +: N];
  assign b_sel   = req_b[gnt_idx*N +: N];
  assign raw_sum = a_sel + b_sel;
  assign pos_ovf = !a_sel[N-1] && !b_sel[N-1] &&  raw_sum[N-1];
  assign neg_ovf =  a_sel[N-1] &&  b_sel[N-1] && !raw_sum[N-1];

  always_comb begin
    sum_sat = raw_sum;
    if (pos_ovf)      sum_sat = POS_MAX;
    else if (neg_ovf) sum_sat = NEG_MAX;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q && !res_ready;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_sat_d   = res_sat_q;
    sat_cnt_d   = sat_cnt_q;
    if (hs) begin
      res_valid_d = 1'b1;
      res_data_d  = sum_sat;
      res_id_d    = gnt_idx;
      res_sat_d   = pos_ovf || neg_ovf;
      rr_ptr_d    = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      if ((pos_ovf || neg_ovf) && !(&sat_cnt_q)) sat_cnt_d = sat_cnt_q + CNTW'(1);
    end
    if (sat_clr) sat_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_sat_q   <= res_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_sat   = res_sat_q;
  assign sat_cnt   = sat_cnt_q;
  assign busy      = res_valid_q || (|req_valid);

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter: saturation vector table plus arbitration,
// backpressure, counter-saturation and mid-operation reset sequences.
module tb_sat_add_arbiter;
  localparam int N    = 25;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;
  localparam int NV   = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              res_valid, res_ready;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_sat;
  logic [CNTW-1:0]   sat_cnt;
  logic              sat_clr;
  logic              busy;

  sat_add_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_sat(res_sat),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   exp;
    logic           sat;
  } vec_t;

  vec_t vt [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_all_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'(i + 1);
      req_b[i*N +: N] = N'(16);
    end
  endtask

  initial begin
    logic [CNTW-1:0] exp_cnt;
    logic [NREQ-1:0] exp_rdy;
    logic [N-1:0]    held;

    vt[0] = '{2'd1, 25'h0800000, 25'h0800000, 25'h0FFFFFF, 1'b1};
    vt[1] = '{2'd2, 25'h1400000, 25'h1400000, 25'h1000001, 1'b1};
    vt[2] = '{2'd2, 25'h1800000, 25'h1800000, 25'h1000000, 1'b0};
    vt[3] = '{2'd0, 25'h0000005, 25'h0000003, 25'h0000008, 1'b0};
    vt[4] = '{2'd3, 25'h0FFFFFF, 25'h0000001, 25'h0FFFFFF, 1'b1};
    vt[5] = '{2'd0, 25'h1000001, 25'h1FFFFFF, 25'h1000000, 1'b0};
    vt[6] = '{2'd1, 25'h1000001, 25'h1FFFFFE, 25'h1000001, 1'b1};
    vt[7] = '{2'd3, 25'h0FFFFFF, 25'h1000000, 25'h1FFFFFF, 1'b0};
    vt[8] = '{2'd2, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFE, 1'b0};
    vt[9] = '{2'd1, 25'h0FFFFFF, 25'h0FFFFFF, 25'h0FFFFFF, 1'b1};

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    sat_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data",  32'(res_data),  32'd0);
    chk("rst_id",    32'(res_id),    32'd0);
    chk("rst_sat",   32'(res_sat),   32'd0);
    chk("rst_cnt",   32'(sat_cnt),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-requester saturation table
    exp_cnt = '0;
    for (int i = 0; i < NV; i++) begin
      req_a = '0;
      req_b = '0;
      req_a[vt[i].id*N +: N] = vt[i].a;
      req_b[vt[i].id*N +: N] = vt[i].b;
      req_valid = '0;
      req_valid[vt[i].id] = 1'b1;
      res_ready = 1'b1;
      exp_rdy = NREQ'(1) << vt[i].id;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk); #1;
      req_valid = '0;
      if (vt[i].sat) exp_cnt = exp_cnt + 1'b1;
      chk("tbl_valid", 32'(res_valid), 32'd1);
      chk("tbl_data",  32'(res_data),  32'(vt[i].exp));
      chk("tbl_id",    32'(res_id),    32'(vt[i].id));
      chk("tbl_sat",   32'(res_sat),   32'(vt[i].sat));
      chk("tbl_cnt",   32'(sat_cnt),   32'(exp_cnt));
    end

    // Mid-operation reset: held result plus pending requests
    @(posedge clk); #1;
    chk("drain_valid", 32'(res_valid), 32'd0);
    set_all_ops();
    req_valid = '1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    chk("pre_rst_id",    32'(res_id),    32'd2);
    chk("stall_ready",   32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data",  32'(res_data),  32'd0);
    chk("mid_rst_id",    32'(res_id),    32'd0);
    chk("mid_rst_sat",   32'(res_sat),   32'd0);
    chk("mid_rst_cnt",   32'(sat_cnt),   32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    res_ready = 1'b1;

    // Fairness: all requesters continuously valid
    for (int i = 0; i < 8; i++) begin
      exp_rdy = NREQ'(1) << (i % NREQ);
      chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk); #1;
      chk("rr_id",    32'(res_id),    32'(i % NREQ));
      chk("rr_valid", 32'(res_valid), 32'd1);
      chk("rr_data",  32'(res_data),  32'((i % NREQ) + 17));
    end

    // Backpressure for 3 cycles, then release
    res_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_id",    32'(res_id),    32'd3);
      chk("bp_data",  32'(res_data),  32'd20);
      chk("bp_rdy",   32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rel_valid", 32'(res_valid), 32'd1);
    chk("rel_id",    32'(res_id),    32'd0);
    held = res_data;
    req_valid = '0;
    @(posedge clk); #1;
    chk("fin_valid", 32'(res_valid), 32'd0);
    chk("fin_hold",  32'(res_data),  32'd17);
    chk("fin_busy",  32'(busy),      32'd0);

    // Saturation counter ceiling and clear priority
    req_a = '0;
    req_b = '0;
    req_a[0 +: N] = 25'h0800000;
    req_b[0 +: N] = 25'h0800000;
    req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_full", 32'(sat_cnt), 32'h0000FFFF);
    @(posedge clk); #1;
    chk("cnt_ceil", 32'(sat_cnt), 32'h0000FFFF);
    chk("cnt_sat",  32'(res_sat), 32'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    chk("cnt_clr",  32'(sat_cnt),  32'd0);
    chk("clr_sat",  32'(res_sat),  32'd1);
    sat_clr = 1'b0;
    @(posedge clk); #1;
    chk("cnt_after", 32'(sat_cnt), 32'd1);
    req_valid = '0;
    @(posedge clk); #1;
    chk("end_valid", 32'(res_valid), 32'd0);
    chk("end_cnt",   32'(sat_cnt),   32'd1);
    chk("end_data",  32'(res_data),  32'h0FFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
